vga_rd_sched: RTL and testbench

Read scheduler for the VGA display path, in the SDRAM clock domain. It keeps the dual-clock VGA FIFO fed by issuing read bursts to the SDRAM controller whenever the FIFO write-side fill level drops below a watermark. It walks the frame buffer address linearly, once per frame. It clears the FIFO and rewinds the address at each frame start. Its outputs drive the SDRAM controller's read-request port and the FIFO's `aclr`.

---
 rtl/vga_sched_pkg.sv | 37 +++
 rtl/vga_addr_gen.sv | 50 +++++
 rtl/vga_rd_sched.sv | 139 +++++++++++++
 tb/tb_vga_rd_sched.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sched_pkg.sv
// Shared types and default constants for the VGA read scheduler.
// Optional ping-pong frame buffer support is selected with VGA_PINGPONG_EN.
package vga_sched_pkg;

    localparam int ADDR_W = 22;
    localparam int REM_W  = 19;
    localparam int LEN_W  = 9;
    localparam int USED_W = 11;
    localparam int CNT_W  = 8;

    localparam int DEF_BURST_LEN   = 256;
    localparam int DEF_LOW_WM      = 512;
    localparam int DEF_FRAME_WORDS = 307200;
    localparam int DEF_CLR_CYC     = 4;
    localparam int DEF_SETTLE_CYC  = 3;

    localparam logic [ADDR_W-1:0] DEF_BASE_ADDR = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_LVL,
        S_REQ,
        S_BURST,
        S_SETTLE,
        S_FDONE
    } sched_state_e;

    // Last burst of a frame is shortened to whatever is left.
    function automatic logic [LEN_W-1:0] burst_len(
        input logic [REM_W-1:0] remain,
        input logic [LEN_W-1:0] max_len
    );
        return (remain < REM_W'(max_len)) ? LEN_W'(remain) : max_len;
    endfunction

endpackage

// File: rtl/vga_addr_gen.sv
// Frame buffer address walker: address/remain registers and burst length.
// With VGA_PINGPONG_EN the frame base follows the bank not being written.
module vga_addr_gen
    import vga_sched_pkg::*;
#(
    parameter int                BURST_LEN   = DEF_BURST_LEN,
    parameter int                FRAME_WORDS = DEF_FRAME_WORDS,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = DEF_BASE_ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
`ifdef VGA_PINGPONG_EN
    input  logic              wr_bank,
`endif
    output logic [ADDR_W-1:0] addr,
    output logic [LEN_W-1:0]  len_m1,
    output logic              remain_zero
);

    logic [REM_W-1:0]  remain;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] load_base;

`ifdef VGA_PINGPONG_EN
    assign load_base = wr_bank ? BASE_ADDR
                               : BASE_ADDR + ADDR_W'(FRAME_WORDS);
`else
    assign load_base = BASE_ADDR;
`endif

    assign len         = burst_len(remain, LEN_W'(BURST_LEN));
    assign len_m1      = len - LEN_W'(1);
    assign remain_zero = (remain == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr   <= BASE_ADDR;
            remain <= '0;
        end else if (load) begin
            addr   <= load_base;
            remain <= REM_W'(FRAME_WORDS);
        end else if (advance) begin
            addr   <= addr + ADDR_W'(len);
            remain <= remain - REM_W'(len);
        end
    end

endmodule

// File: rtl/vga_rd_sched.sv
// VGA read scheduler: keeps the display FIFO fed with SDRAM read bursts.
// Define VGA_PINGPONG_EN to add wr_bank_i and read the opposite bank.
module vga_rd_sched
    import vga_sched_pkg::*;
#(
    parameter int                BURST_LEN   = DEF_BURST_LEN,
    parameter int                LOW_WM      = DEF_LOW_WM,
    parameter int                FRAME_WORDS = DEF_FRAME_WORDS,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int                CLR_CYC     = DEF_CLR_CYC,
    parameter int                SETTLE_CYC  = DEF_SETTLE_CYC
) (
    input  logic              clk_133M_i,
    input  logic              nrst_i,
    input  logic              frame_start_i,
    input  logic [USED_W-1:0] fifo_used_i,
`ifdef VGA_PINGPONG_EN
    input  logic              wr_bank_i,
`endif
    output logic              rd_req_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [LEN_W-1:0]  rd_len_o,
    input  logic              rd_ack_i,
    input  logic              rd_done_i,
    output logic              fifo_clear_o,
    output logic              frame_done_o,
    output logic              busy_o
);

    localparam logic [USED_W-1:0] LOW_WM_V    = USED_W'(LOW_WM);
    localparam logic [CNT_W-1:0]  CLR_LAST    = CNT_W'(CLR_CYC - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    sched_state_e      state;
    logic [CNT_W-1:0]  cnt;
    logic              pend_start;

    logic              start_ok;
    logic              burst_end;
    logic              load;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len_m1;
    logic              remain_zero;

    assign start_ok  = frame_start_i &&
                       (state == S_IDLE || state == S_WAIT_LVL ||
                        state == S_SETTLE || state == S_FDONE);
    assign burst_end = (state == S_BURST) && rd_done_i;
    // A start seen during an in-flight burst restarts once it completes.
    assign load      = start_ok ||
                       (burst_end && (pend_start || frame_start_i));

    vga_addr_gen #(
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS),
        .BASE_ADDR   (BASE_ADDR)
    ) u_addr (
        .clk         (clk_133M_i),
        .rst_n       (nrst_i),
        .load        (load),
        .advance     (burst_end),
`ifdef VGA_PINGPONG_EN
        .wr_bank     (wr_bank_i),
`endif
        .addr        (addr),
        .len_m1      (len_m1),
        .remain_zero (remain_zero)
    );

    always_ff @(posedge clk_133M_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state        <= S_IDLE;
            cnt          <= '0;
            pend_start   <= 1'b0;
            rd_req_o     <= 1'b0;
            rd_addr_o    <= BASE_ADDR;
            rd_len_o     <= '0;
            fifo_clear_o <= 1'b0;
            frame_done_o <= 1'b0;
            busy_o       <= 1'b0;
        end else if (load) begin
            state        <= S_CLEAR;
            cnt          <= '0;
            pend_start   <= 1'b0;
            fifo_clear_o <= 1'b1;
            frame_done_o <= 1'b0;
            busy_o       <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE, S_FDONE: begin
                end
                S_CLEAR: begin
                    if (cnt == CLR_LAST) begin
                        state        <= S_WAIT_LVL;
                        fifo_clear_o <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WAIT_LVL: begin
                    if (remain_zero) begin
                        state        <= S_FDONE;
                        frame_done_o <= 1'b1;
                        busy_o       <= 1'b0;
                    end else if (fifo_used_i < LOW_WM_V) begin
                        state     <= S_REQ;
                        rd_req_o  <= 1'b1;
                        rd_addr_o <= addr;
                        rd_len_o  <= len_m1;
                    end
                end
                S_REQ: begin
                    if (frame_start_i)
                        pend_start <= 1'b1;
                    if (rd_ack_i) begin
                        state    <= S_BURST;
                        rd_req_o <= 1'b0;
                    end
                end
                S_BURST: begin
                    if (frame_start_i)
                        pend_start <= 1'b1;
                    if (rd_done_i) begin
                        state <= S_SETTLE;
                        cnt   <= '0;
                    end
                end
                S_SETTLE: begin
                    if (cnt == SETTLE_LAST)
                        state <= S_WAIT_LVL;
                    else
                        cnt <= cnt + CNT_W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_rd_sched.sv
// Self-checking bench for vga_rd_sched: frame model plus directed scenarios.
// Also builds with VGA_PINGPONG_EN (reads the bank opposite wr_bank_i=0).
module tb_vga_rd_sched;
    import vga_sched_pkg::*;

    localparam int FW  = 307200;
    localparam int BL  = 256;
    localparam int SFW = 1000;
`ifdef VGA_PINGPONG_EN
    localparam int M_BASE = FW;
    localparam int S_BASE = SFW;
`else
    localparam int M_BASE = 0;
    localparam int S_BASE = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        fs = 1'b0;
    logic [10:0] used = '0;
    logic        ack = 1'b0;
    logic        done = 1'b0;
    logic        rd_req;
    logic [21:0] rd_addr;
    logic [8:0]  rd_len;
    logic        clr, fdone, busy;

    logic        fs_s = 1'b0;
    logic [10:0] used_s = '0;
    logic        ack_s = 1'b0;
    logic        done_s = 1'b0;
    logic        req_s;
    logic [21:0] addr_s;
    logic [8:0]  len_s;
    logic        clr_s, fdone_s, busy_s;
`ifdef VGA_PINGPONG_EN
    logic        wr_bank = 1'b0;
`endif

    vga_rd_sched dut (
        .clk_133M_i    (clk),
        .nrst_i        (rst_n),
        .frame_start_i (fs),
        .fifo_used_i   (used),
`ifdef VGA_PINGPONG_EN
        .wr_bank_i     (wr_bank),
`endif
        .rd_req_o      (rd_req),
        .rd_addr_o     (rd_addr),
        .rd_len_o      (rd_len),
        .rd_ack_i      (ack),
        .rd_done_i     (done),
        .fifo_clear_o  (clr),
        .frame_done_o  (fdone),
        .busy_o        (busy)
    );

    vga_rd_sched #(.FRAME_WORDS(SFW)) dut_s (
        .clk_133M_i    (clk),
        .nrst_i        (rst_n),
        .frame_start_i (fs_s),
        .fifo_used_i   (used_s),
`ifdef VGA_PINGPONG_EN
        .wr_bank_i     (wr_bank),
`endif
        .rd_req_o      (req_s),
        .rd_addr_o     (addr_s),
        .rd_len_o      (len_s),
        .rd_ack_i      (ack_s),
        .rd_done_i     (done_s),
        .fifo_clear_o  (clr_s),
        .frame_done_o  (fdone_s),
        .busy_o        (busy_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_run = 0;
    int n_fail = 0;
    int m_k = 0;
    int m_clr = -100;
    bit chk_en = 1'b0;

    function automatic logic [21:0] m_addr(input int k);
        return 22'((M_BASE + k * BL) % (1 << 22));
    endfunction

    function automatic logic [8:0] m_len(input int k);
        int r;
        r = FW - k * BL;
        return 9'(((r < BL) ? r : BL) - 1);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 40; i++) begin
            if (rd_req) break;
            step();
        end
        chk("req_timeout", 64'(rd_req), 64'd1);
    endtask

    // Model: clear window follows the accepted start edge; every request
    // must carry the k-th burst address/length of the current frame.
    always @(negedge clk) begin
        int d;
        if (rst_n && chk_en) begin
            d = cyc - m_clr;
            chk("clear_win", 64'(clr), 64'(d >= 0 && d < 4));
            if (clr) chk("clr_busy", 64'(busy), 64'd1);
            if (rd_req) begin
                chk("req_addr", 64'(rd_addr), 64'(m_addr(m_k)));
                chk("req_len", 64'(rd_len), 64'(m_len(m_k)));
                chk("req_fdone", 64'(fdone), 64'd0);
                chk("req_busy", 64'(busy), 64'd1);
                chk("req_left", 64'(m_k * BL < FW), 64'd1);
            end
        end
    end

    initial begin
        int nclr, nb, found;
        logic [21:0] last;
        logic [8:0]  lens [8];
        logic [21:0] addrs [8];

        repeat (3) step();
        chk("rst_req", 64'(rd_req), 64'd0);
        chk("rst_addr", 64'(rd_addr), 64'd0);
        chk("rst_len", 64'(rd_len), 64'd0);
        chk("rst_clr", 64'(clr), 64'd0);
        chk("rst_fdone", 64'(fdone), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        rst_n = 1'b1;
        chk_en = 1'b1;
        step();
        fs = 1'b1;
        step();
        fs = 1'b0;
        m_clr = cyc;
        m_k = 0;
        nclr = 0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (clr) nclr++;
            if (rd_req) begin
                found = 1;
                break;
            end
            step();
        end
        chk("clear_len", 64'(nclr), 64'd4);
        chk("first_req", 64'(found), 64'd1);
        chk("first_addr", 64'(rd_addr), 64'(M_BASE));
        chk("first_len", 64'(rd_len), 64'd255);

        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("req_drop", 64'(rd_req), 64'd0);
        step();
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        m_k = 1;
        used = 11'd600;
        repeat (6) step();
        ack = 1'b1;
        done = 1'b1;
        step();
        ack = 1'b0;
        done = 1'b0;
        repeat (6) step();
        chk("hold_noreq", 64'(rd_req), 64'd0);
        chk("hold_busy", 64'(busy), 64'd1);
        used = 11'd511;
        step();
        chk("wm_req", 64'(rd_req), 64'd1);
        chk("second_addr", 64'(rd_addr), 64'(M_BASE + 256));
        used = '0;

        nb = 1;
        last = '0;
        for (int i = 0; i < 20000 && !fdone; i++) begin
            if (rd_req) begin
                last = rd_addr;
                ack = 1'b1;
                step();
                ack = 1'b0;
                step();
                step();
                done = 1'b1;
                step();
                done = 1'b0;
                m_k++;
                nb++;
            end else begin
                step();
            end
        end
        chk("frame_fdone", 64'(fdone), 64'd1);
        chk("burst_cnt", 64'(nb), 64'd1200);
        chk("last_addr", 64'(last), 64'(M_BASE + 306944));
        chk("fdone_busy", 64'(busy), 64'd0);

        fs = 1'b1;
        step();
        fs = 1'b0;
        m_clr = cyc;
        m_k = 0;
        chk("fdone_drop", 64'(fdone), 64'd0);
        wait_req();
        ack = 1'b1;
        step();
        ack = 1'b0;
        fs = 1'b1;
        step();
        fs = 1'b0;
        repeat (5) step();
        chk("pend_noclr", 64'(clr), 64'd0);
        chk("pend_busy", 64'(busy), 64'd1);
        done = 1'b1;
        step();
        done = 1'b0;
        m_clr = cyc;
        m_k = 0;
        chk("pend_clr", 64'(clr), 64'd1);
        wait_req();
        chk("pend_addr", 64'(rd_addr), 64'(M_BASE));

        fs = 1'b1;
        step();
        fs = 1'b0;
        repeat (3) step();
        chk("reqpend_hold", 64'(rd_req), 64'd1);
        chk("reqpend_noclr", 64'(clr), 64'd0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        m_clr = cyc;
        m_k = 0;
        chk("reqpend_clr", 64'(clr), 64'd1);

        wait_req();
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", 64'(rd_req), 64'd0);
        chk("arst_addr", 64'(rd_addr), 64'd0);
        chk("arst_len", 64'(rd_len), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_clr", 64'(clr), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        fs_s = 1'b1;
        step();
        fs_s = 1'b0;
        nb = 0;
        for (int i = 0; i < 400 && !fdone_s; i++) begin
            if (req_s) begin
                if (nb < 8) begin
                    lens[nb]  = len_s;
                    addrs[nb] = addr_s;
                end
                ack_s = 1'b1;
                step();
                ack_s = 1'b0;
                step();
                done_s = 1'b1;
                step();
                done_s = 1'b0;
                nb++;
            end else begin
                step();
            end
        end
        chk("s_bursts", 64'(nb), 64'd4);
        chk("s_fdone", 64'(fdone_s), 64'd1);
        if (nb == 4) begin
            chk("s_len0", 64'(lens[0]), 64'd255);
            chk("s_len3", 64'(lens[3]), 64'd231);
            chk("s_addr3", 64'(addrs[3]), 64'(S_BASE + 768));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
